div_share_ctrl: RTL and testbench
=================================

# div_share_ctrl

Round-robin scheduler and sequencer for a shared restoring-division datapath. Two requesters each present a dividend/divisor pair. The block grants one requester at a time, steps the datapath through load, shift, trial-subtract and restore phases, and returns the quotient and remainder with a valid/ready response handshake. It sits between the board-level operand sources (switch banks or upstream FSMs) and the HEX/LEDR result display logic.

## Interface
- WIDTH, default 4: operand, quotient and remainder width in bits.
- CLOCK_50  in  1  system clock, rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- req  in  2  per-requester request level; held high until that requester's grant bit pulses.
- dividend0, divisor0  in  WIDTH each  requester 0 operands; must be stable while req[0] is high.
- dividend1, divisor1  in  WIDTH each  requester 1 operands; must be stable while req[1] is high.
- grant  out  2  one-hot; high for exactly the LOAD cycle; acknowledges the request.
- busy  out  1  high in every state except IDLE.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  1  index of the requester that owns the result.
- quotient, remainder  out  WIDTH each  result.
- div_zero  out  1  result came from a zero divisor.

## Operation
- States: IDLE, LOAD, SHIFT, SUB, RESTORE, RESP.
- IDLE: if any req bit is set, go to LOAD. The winner is latched in that same transition.
- Arbitration is round-robin on the last_grant register:
  - Both requesting: winner = ~last_grant.
  - One requesting: that one wins.
  - last_grant resets to 1, so requester 0 wins the first tie.
  - last_grant updates on entry to LOAD.
- LOAD:
  - grant[winner]=1.
  - Capture operands: M = divisor, Q = dividend, A = 0 (WIDTH+1 bits, two's complement), cnt = 0.
  - Divisor == 0: go to RESP with quotient = all ones, remainder = dividend, div_zero = 1.
  - Otherwise go to SHIFT.
- SHIFT: {A,Q} <<= 1. Go to SUB.
- SUB: A = A − M; Q[0] = ~A_new[WIDTH]. Go to RESTORE.
- RESTORE:
  - If A[WIDTH]=1, A = A + M; otherwise hold. This state always takes one cycle.
  - If cnt == WIDTH−1, go to RESP. Otherwise cnt++ and go to SHIFT.
- RESP:
  - Drive quotient = Q, remainder = A[WIDTH-1:0], rsp_id, div_zero; rsp_valid = 1.
  - On rsp_valid & rsp_ready, go to IDLE.
- Requests arriving while busy are ignored until IDLE; no queuing.
- A req dropped before its grant is never served.
- Width rules:
  - A is WIDTH+1 bits; all add/subtract is done at WIDTH+1 bits; no overflow is possible.
  - cnt is $clog2(WIDTH) bits, minimum 1.

## Timing
- Reset values: grant=0, busy=0, rsp_valid=0, rsp_id=0, quotient=0, remainder=0, div_zero=0, state=IDLE, last_grant=1.
- Reset is asynchronous: asserting resetn low mid-operation clears all outputs and registers immediately. The in-flight job is discarded and no response is issued.
- Latency, with req sampled in IDLE on edge t (state IDLE during cycle t):
  - LOAD/grant during cycle t+1.
  - Normal division: rsp_valid from cycle t+2+3·WIDTH (t+14 for WIDTH=4).
  - Zero divisor: rsp_valid from cycle t+2.
- RESP back-pressure: quotient, remainder, rsp_id, div_zero and rsp_valid hold stable while rsp_ready=0. The handshake completes on the edge where both are high.
- After acceptance, the earliest next grant is two cycles later (IDLE, then LOAD).
- grant is Moore-decoded from state; all other outputs are registered.

## Structure
- Package div_share_pkg:
  - State localparams, 3-bit encoding.
  - Requester-count constant NREQ=2.
- Sub-module div_step_datapath:
  - Holds A, Q, M registers.
  - Control inputs: load, shift, sub, restore.
  - Status output: sign = A[WIDTH].
- The controller owns the FSM, cnt, arbitration and response registers.

## Test plan
- req[0] with 7/2, rsp_ready=1 → grant=01 at t+1; rsp_valid at t+14; quotient=3, remainder=1, rsp_id=0, div_zero=0.
- req[1] with 15/1 → quotient=F, remainder=0, rsp_id=1. Then 0/5 → quotient=0, remainder=0.
- req[0] with 13/0 → rsp_valid at t+2; quotient=F, remainder=D, div_zero=1.
- After reset, req=11 with 9/3 and 8/5 held:
  - requester 0 served first (q=3, r=0), then requester 1 (q=1, r=3).
  - Reasserting both afterwards → grant=10 first.
- rsp_ready low for 5 cycles in RESP → outputs stable, busy=1, no grant even with req[1] high. Release → accept, then grant at +2.
- resetn low during SUB → all outputs 0 without waiting for a clock edge. After release: no spurious rsp_valid, and a tie grants requester 0.

Source files
------------

// File: rtl/div_share_pkg.sv
// Shared types and constants for the two-requester division sequencer.
package div_share_pkg;

    localparam int NREQ = 2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SHIFT   = 3'd2,
        S_SUB     = 3'd3,
        S_RESTORE = 3'd4,
        S_RESP    = 3'd5
    } state_t;

    function automatic logic [NREQ-1:0] onehot(input logic idx);
        return NREQ'(1) << idx;
    endfunction

endpackage

// File: rtl/div_step_datapath.sv
// Restoring-division register file: A (WIDTH+1, two's complement), Q and M,
// stepped one phase per cycle by the controller.
module div_step_datapath #(
    parameter int WIDTH = 4
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    input  logic             load,
    input  logic             shift,
    input  logic             sub,
    input  logic             restore,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             sign,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem
);

    logic [WIDTH:0]   a;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;
    logic [WIDTH:0]   a_sub;
    logic [WIDTH:0]   a_add;

    assign a_sub = a - {1'b0, m};
    assign a_add = a + {1'b0, m};
    assign sign  = a[WIDTH];
    assign quo   = q;
    // Remainder as it will look after the pending restore, so the final
    // RESTORE cycle can hand the result straight to the response registers.
    assign rem   = a[WIDTH] ? a_add[WIDTH-1:0] : a[WIDTH-1:0];

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            a <= '0;
            q <= '0;
            m <= '0;
        end else if (load) begin
            a <= '0;
            q <= dividend;
            m <= divisor;
        end else if (shift) begin
            {a, q} <= {a[WIDTH-1:0], q, 1'b0};
        end else if (sub) begin
            a    <= a_sub;
            q[0] <= ~a_sub[WIDTH];
        end else if (restore) begin
            a <= a_add;
        end
    end

endmodule

// File: rtl/div_share_ctrl.sv
// Round-robin arbiter and phase sequencer sharing one restoring divider
// between two requesters, with a valid/ready result port.
module div_share_ctrl
    import div_share_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic [NREQ-1:0]   req,
    input  logic [WIDTH-1:0]  dividend0,
    input  logic [WIDTH-1:0]  divisor0,
    input  logic [WIDTH-1:0]  dividend1,
    input  logic [WIDTH-1:0]  divisor1,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [WIDTH-1:0]  quotient,
    output logic [WIDTH-1:0]  remainder,
    output logic              div_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    logic             last_grant;
    logic             win_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sel_dvd;
    logic [WIDTH-1:0] sel_dvs;
    logic             dp_sign;
    logic [WIDTH-1:0] dp_quo;
    logic [WIDTH-1:0] dp_rem;

    // last_grant doubles as the owner of the in-flight job.
    assign win_nxt = (req == 2'b11) ? ~last_grant : req[1];
    assign sel_dvd = last_grant ? dividend1 : dividend0;
    assign sel_dvs = last_grant ? divisor1  : divisor0;
    assign grant   = (state == S_LOAD) ? onehot(last_grant) : '0;

    div_step_datapath #(.WIDTH(WIDTH)) u_dp (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .load     (state == S_LOAD),
        .shift    (state == S_SHIFT),
        .sub      (state == S_SUB),
        .restore  ((state == S_RESTORE) && dp_sign),
        .dividend (sel_dvd),
        .divisor  (sel_dvs),
        .sign     (dp_sign),
        .quo      (dp_quo),
        .rem      (dp_rem)
    );

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            cnt        <= '0;
            busy       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            quotient   <= '0;
            remainder  <= '0;
            div_zero   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        state      <= S_LOAD;
                        last_grant <= win_nxt;
                        busy       <= 1'b1;
                    end
                end
                S_LOAD: begin
                    cnt    <= '0;
                    rsp_id <= last_grant;
                    if (sel_dvs == '0) begin
                        state     <= S_RESP;
                        quotient  <= '1;
                        remainder <= sel_dvd;
                        div_zero  <= 1'b1;
                        rsp_valid <= 1'b1;
                    end else begin
                        state    <= S_SHIFT;
                        div_zero <= 1'b0;
                    end
                end
                S_SHIFT: state <= S_SUB;
                S_SUB:   state <= S_RESTORE;
                S_RESTORE: begin
                    if (cnt == CW'(WIDTH - 1)) begin
                        state     <= S_RESP;
                        quotient  <= dp_quo;
                        remainder <= dp_rem;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        state <= S_SHIFT;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed bench: stimulus pushes expected results into a scoreboard that a
// forked monitor drains on every accepted response.
module tb_div_share_ctrl;

    localparam int W = 4;

    logic         CLOCK_50 = 1'b0;
    logic         resetn   = 1'b0;
    logic [1:0]   req      = 2'b00;
    logic [W-1:0] dividend0 = '0, divisor0 = '0, dividend1 = '0, divisor1 = '0;
    logic         rsp_ready = 1'b1;
    logic [1:0]   grant;
    logic         busy, rsp_valid, rsp_id, div_zero;
    logic [W-1:0] quotient, remainder;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic         id;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    exp_t sb[$];

    div_share_ctrl #(.WIDTH(W)) dut (
        .CLOCK_50  (CLOCK_50),
        .resetn    (resetn),
        .req       (req),
        .dividend0 (dividend0),
        .divisor0  (divisor0),
        .dividend1 (dividend1),
        .divisor1  (divisor1),
        .grant     (grant),
        .busy      (busy),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic tick;
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic id, input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
        exp_t e;
        e.id = id; e.q = q; e.r = r; e.dz = dz;
        sb.push_back(e);
    endtask

    task automatic monitor;
        exp_t e;
        forever begin
            @(negedge CLOCK_50);
            if (resetn && rsp_valid && rsp_ready) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_rsp: id=%0d q=%0h r=%0h dz=%0d with empty scoreboard",
                             rsp_id, quotient, remainder, div_zero);
                end else begin
                    e = sb.pop_front();
                    if ({rsp_id, quotient, remainder, div_zero} !== e) begin
                        n_err++;
                        $display("FAIL rsp: got id=%0d q=%0h r=%0h dz=%0d, expected id=%0d q=%0h r=%0h dz=%0d",
                                 rsp_id, quotient, remainder, div_zero, e.id, e.q, e.r, e.dz);
                    end
                end
            end
        end
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
        chk(name, rsp_valid, 1);
    endtask

    // Single request from IDLE with exact latency checks; lat counts cycles
    // from the LOAD cycle to the first RESP cycle.
    task automatic serve(input logic id, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                         input logic [W-1:0] q, input logic [W-1:0] r, input logic dz,
                         input int lat);
        if (id) begin dividend1 = dvd; divisor1 = dvs; end
        else    begin dividend0 = dvd; divisor0 = dvs; end
        push(id, q, r, dz);
        req[id] = 1'b1;
        tick();
        chk("grant", grant, id ? 2'b10 : 2'b01);
        chk("busy_load", busy, 1);
        req[id] = 1'b0;
        chk("valid_in_load", rsp_valid, 0);
        repeat (lat - 1) tick();
        chk("valid_early", rsp_valid, 0);
        tick();
        chk("valid_on_time", rsp_valid, 1);
        tick();
        chk("idle_after_accept", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            monitor();
        join_none

        // reset state
        #3;
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_id", rsp_id, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dz", div_zero, 0);
        tick(); tick();
        resetn = 1'b1;
        tick();

        serve(1'b0, 4'd7,  4'd2, 4'd3, 4'd1, 1'b0, 13);
        serve(1'b1, 4'd15, 4'd1, 4'hF, 4'd0, 1'b0, 13);
        serve(1'b1, 4'd0,  4'd5, 4'd0, 4'd0, 1'b0, 13);
        serve(1'b0, 4'd13, 4'd0, 4'hF, 4'hD, 1'b1, 1);

        // tie right after reset: requester 0 first
        resetn = 1'b0; tick(); resetn = 1'b1; tick();
        dividend0 = 4'd9; divisor0 = 4'd3; dividend1 = 4'd8; divisor1 = 4'd5;
        push(1'b0, 4'd3, 4'd0, 1'b0);
        push(1'b1, 4'd1, 4'd3, 1'b0);
        req = 2'b11;
        tick();
        chk("tie0_grant", grant, 2'b01);
        req[0] = 1'b0;
        wait_valid("tie0_wait");
        tick(); tick();
        chk("tie0_second_grant", grant, 2'b10);
        req = 2'b00;
        wait_valid("tie0_wait2");
        tick();

        // requester 0 served last, so the next tie goes to requester 1
        serve(1'b0, 4'd6, 4'd4, 4'd1, 4'd2, 1'b0, 13);
        dividend0 = 4'd14; divisor0 = 4'd3; dividend1 = 4'd5; divisor1 = 4'd2;
        push(1'b1, 4'd2, 4'd1, 1'b0);
        push(1'b0, 4'd4, 4'd2, 1'b0);
        req = 2'b11;
        tick();
        chk("tie1_grant", grant, 2'b10);
        req[1] = 1'b0;
        wait_valid("tie1_wait");
        tick(); tick();
        chk("tie1_second_grant", grant, 2'b01);
        req = 2'b00;
        wait_valid("tie1_wait2");
        tick();

        // back-pressure in RESP with a competing request pending
        rsp_ready = 1'b0;
        dividend0 = 4'd11; divisor0 = 4'd4;
        push(1'b0, 4'd2, 4'd3, 1'b0);
        req[0] = 1'b1;
        tick();
        chk("bp_grant", grant, 2'b01);
        req[0] = 1'b0;
        wait_valid("bp_wait");
        dividend1 = 4'd10; divisor1 = 4'd3;
        push(1'b1, 4'd3, 4'd1, 1'b0);
        req[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", rsp_valid, 1);
            chk("bp_busy", busy, 1);
            chk("bp_nogrant", grant, 0);
            chk("bp_q", quotient, 4'd2);
            chk("bp_r", remainder, 4'd3);
            chk("bp_id", rsp_id, 0);
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_idle_grant", grant, 0);
        chk("bp_idle_busy", busy, 0);
        tick();
        chk("bp_next_grant", grant, 2'b10);
        req = 2'b00;
        wait_valid("bp_wait2");
        tick();

        // asynchronous reset during SUB discards the job
        dividend0 = 4'd9; divisor0 = 4'd2;
        req[0] = 1'b1;
        tick();
        req[0] = 1'b0;
        tick(); tick();
        #2 resetn = 1'b0;
        #1;
        chk("arst_grant", grant, 0);
        chk("arst_busy", busy, 0);
        chk("arst_valid", rsp_valid, 0);
        chk("arst_id", rsp_id, 0);
        chk("arst_q", quotient, 0);
        chk("arst_r", remainder, 0);
        chk("arst_dz", div_zero, 0);
        tick(); tick();
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("arst_no_spurious", rsp_valid, 0);
        end
        dividend0 = 4'd9; divisor0 = 4'd3; dividend1 = 4'd8; divisor1 = 4'd5;
        push(1'b0, 4'd3, 4'd0, 1'b0);
        push(1'b1, 4'd1, 4'd3, 1'b0);
        req = 2'b11;
        tick();
        chk("arst_tie_grant", grant, 2'b01);
        req[0] = 1'b0;
        wait_valid("arst_wait");
        tick(); tick();
        chk("arst_second_grant", grant, 2'b10);
        req = 2'b00;
        wait_valid("arst_wait2");
        tick(); tick();

        chk("scoreboard_empty", 8'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
